// File: rtl/async_fifo_pkg.sv
// Shared sizing defaults and operation encoding for the single-clock FIFO
// built around the fifo_mem storage array.
package async_fifo_pkg;

   localparam int DSIZE_DEF = 8;
   localparam int ASIZE_DEF = 4;

   typedef enum logic [1:0] {
      OP_IDLE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_BOTH  = 2'b11
   } fifo_op_e;

   // Requests are expected to be already qualified against the current flags
   function automatic fifo_op_e op_decode(input logic wr_en, input logic rd_en);
      fifo_op_e op;
      case ({wr_en, rd_en})
         2'b00:   op = OP_IDLE;
         2'b01:   op = OP_READ;
         2'b10:   op = OP_WRITE;
         2'b11:   op = OP_BOTH;
         default: op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// 2**ASIZE x DSIZE storage: synchronous write, asynchronous read.
// Contents are deliberately not reset; the pointers decide what is valid.
module fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF
) (
   input  logic             wclk,
   input  logic             wen,
   input  logic [ASIZE-1:0] waddr,
   input  logic [DSIZE-1:0] wdata,
   input  logic [ASIZE-1:0] raddr,
   output logic [DSIZE-1:0] rdata
);

   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem_r [DEPTH];

   // Storage write port
   always_ff @(posedge wclk) begin
      if (wen) begin
         mem_r[waddr] <= wdata;
      end else begin
         mem_r[waddr] <= mem_r[waddr];
      end
   end

   assign rdata = mem_r[raddr];

endmodule

// File: rtl/async_fifo.sv
// Single-clock FIFO with first-word fall-through output. Flags are registered
// from the next-state pointers so they are correct right after each edge.
module async_fifo
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = DSIZE_DEF,
   parameter int ASIZE = ASIZE_DEF
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic             winc,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rinc,
   output logic [DSIZE-1:0] rdata,
   output logic             wfull,
   output logic             rempty
);

   localparam logic [ASIZE:0] PTR_ZERO = {(ASIZE+1){1'b0}};
   localparam logic [ASIZE:0] PTR_ONE  = {{ASIZE{1'b0}}, 1'b1};

   logic [ASIZE:0]   wptr_r;
   logic [ASIZE:0]   rptr_r;
   logic [ASIZE:0]   wptr_next_s;
   logic [ASIZE:0]   rptr_next_s;
   logic             wfull_r;
   logic             rempty_r;
   logic             wr_en_s;
   logic             rd_en_s;
   logic [DSIZE-1:0] mem_rdata_s;
   fifo_op_e         op_s;

   // Pointers carry one extra wrap bit so full and empty are distinguishable
   function automatic logic ptr_empty(input logic [ASIZE:0] wp, input logic [ASIZE:0] rp);
      return (wp == rp);
   endfunction

   function automatic logic ptr_full(input logic [ASIZE:0] wp, input logic [ASIZE:0] rp);
      return (wp[ASIZE-1:0] == rp[ASIZE-1:0]) && (wp[ASIZE] != rp[ASIZE]);
   endfunction

   assign wr_en_s = winc & ~wfull_r;
   assign rd_en_s = rinc & ~rempty_r;

   // Decode the qualified requests and advance the pointers accordingly
   always_comb begin
      op_s        = op_decode(wr_en_s, rd_en_s);
      wptr_next_s = wptr_r;
      rptr_next_s = rptr_r;
      case (op_s)
         OP_IDLE: begin
            wptr_next_s = wptr_r;
            rptr_next_s = rptr_r;
         end
         OP_WRITE: begin
            wptr_next_s = wptr_r + PTR_ONE;
         end
         OP_READ: begin
            rptr_next_s = rptr_r + PTR_ONE;
         end
         OP_BOTH: begin
            wptr_next_s = wptr_r + PTR_ONE;
            rptr_next_s = rptr_r + PTR_ONE;
         end
         default: begin
            wptr_next_s = wptr_r;
            rptr_next_s = rptr_r;
         end
      endcase
   end

   // Pointer and flag state
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wptr_r   <= PTR_ZERO;
         rptr_r   <= PTR_ZERO;
         rempty_r <= 1'b1;
         wfull_r  <= 1'b0;
      end else begin
         wptr_r   <= wptr_next_s;
         rptr_r   <= rptr_next_s;
         rempty_r <= ptr_empty(wptr_next_s, rptr_next_s);
         wfull_r  <= ptr_full(wptr_next_s, rptr_next_s);
      end
   end

   fifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .wclk  (wclk),
      .wen   (wr_en_s),
      .waddr (wptr_r[ASIZE-1:0]),
      .wdata (wdata),
      .raddr (rptr_r[ASIZE-1:0]),
      .rdata (mem_rdata_s)
   );

   // Stale memory contents never leak out while the queue is empty
   always_comb begin
      if (rempty_r) begin
         rdata = {DSIZE{1'b0}};
      end else begin
         rdata = mem_rdata_s;
      end
   end

   assign wfull  = wfull_r;
   assign rempty = rempty_r;

endmodule

// File: tb/tb_async_fifo.sv
// Self-checking bench for async_fifo: directed scenarios plus random traffic,
// all compared against a queue-based reference model.
module tb_async_fifo;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          wclk;
   logic          wrst_n;
   logic          winc;
   logic [DW-1:0] wdata;
   logic          rinc;
   logic [DW-1:0] rdata;
   logic          wfull;
   logic          rempty;

   int tests_run = 0;
   int tests_failed = 0;

   logic [DW-1:0] model_q[$];

   async_fifo #(.DSIZE(DW), .ASIZE(AW)) dut (
      .wclk   (wclk),
      .wrst_n (wrst_n),
      .winc   (winc),
      .wdata  (wdata),
      .rinc   (rinc),
      .rdata  (rdata),
      .wfull  (wfull),
      .rempty (rempty)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // One clock edge of stimulus; the model follows the queue rules directly
   task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
      bit was_full;
      bit was_empty;
      winc  = w;
      wdata = d;
      rinc  = r;
      @(posedge wclk);
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      if (r && !was_empty) void'(model_q.pop_front());
      if (w && !was_full) model_q.push_back(d);
      #1;
      winc = 1'b0;
      rinc = 1'b0;
   endtask

   task automatic test_reset();
      winc = 1'b0; rinc = 1'b0; wdata = '0;
      wrst_n = 1'b0;
      model_q.delete();
      #250;
      tests_run++;
      if (rempty !== 1'b1 || wfull !== 1'b0 || rdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_during: rempty=%b wfull=%b rdata=%h, want 1 0 00", rempty, wfull, rdata);
      end
      #250;
      wrst_n = 1'b1;
      @(posedge wclk); #1;
      tests_run++;
      if (rempty !== 1'b1 || wfull !== 1'b0 || rdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_after: rempty=%b wfull=%b rdata=%h, want 1 0 00", rempty, wfull, rdata);
      end
   endtask

   task automatic test_basic_write();
      step(1'b1, 8'd1, 1'b0);
      tests_run++;
      if (rempty !== 1'b0 || rdata !== 8'd1) begin
         tests_failed++;
         $display("FAIL first_write: rempty=%b rdata=%h, want 0 01", rempty, rdata);
      end
      step(1'b1, 8'd2, 1'b0);
      step(1'b1, 8'd3, 1'b0);
      step(1'b0, 8'd0, 1'b0);
      tests_run++;
      if (rempty !== 1'b0 || wfull !== 1'b0 || rdata !== 8'd1) begin
         tests_failed++;
         $display("FAIL three_writes: rempty=%b wfull=%b rdata=%h, want 0 0 01", rempty, wfull, rdata);
      end
   endtask

   task automatic test_basic_read();
      logic [DW-1:0] exp_seq [4];
      logic          do_rd   [4];
      exp_seq = '{8'd2, 8'd3, 8'd3, 8'd0};
      do_rd   = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'd0, do_rd[i]);
         tests_run++;
         if (rdata !== exp_seq[i]) begin
            tests_failed++;
            $display("FAIL read_seq[%0d]: rdata=%h, want %h", i, rdata, exp_seq[i]);
         end
      end
      tests_run++;
      if (rempty !== 1'b1) begin
         tests_failed++;
         $display("FAIL read_empty: rempty=%b, want 1", rempty);
      end
   endtask

   task automatic test_full();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, DW'(i), 1'b0);
         tests_run++;
         if (wfull !== (i >= 15)) begin
            tests_failed++;
            $display("FAIL full_flag[%0d]: wfull=%b, want %b", i, wfull, (i >= 15));
         end
      end
      for (int i = 0; i < 16; i++) begin
         tests_run++;
         if (rdata !== DW'(i) || rempty !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_drain[%0d]: rdata=%h rempty=%b, want %h 0", i, rdata, rempty, DW'(i));
         end
         step(1'b0, 8'd0, 1'b1);
      end
      tests_run++;
      if (rempty !== 1'b1 || wfull !== 1'b0 || rdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL full_drained: rempty=%b wfull=%b rdata=%h, want 1 0 00", rempty, wfull, rdata);
      end
   endtask

   task automatic test_simul();
      for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(i + 100), 1'b0);
      step(1'b1, 8'hEE, 1'b1);
      tests_run++;
      if (wfull !== 1'b0 || rdata !== 8'd101 || rempty !== 1'b0) begin
         tests_failed++;
         $display("FAIL both_when_full: wfull=%b rdata=%h rempty=%b, want 0 65 0", wfull, rdata, rempty);
      end
      // Both qualified mid-range: occupancy and flags stay put
      step(1'b1, 8'h77, 1'b1);
      tests_run++;
      if (wfull !== 1'b0 || rempty !== 1'b0 || rdata !== 8'd102 || model_q.size() != DEPTH - 1) begin
         tests_failed++;
         $display("FAIL both_mid: wfull=%b rempty=%b rdata=%h, want 0 0 66", wfull, rempty, rdata);
      end
      while (model_q.size() != 0) step(1'b0, 8'd0, 1'b1);
      step(1'b1, 8'h5A, 1'b1);
      tests_run++;
      if (rempty !== 1'b0 || rdata !== 8'h5A || wfull !== 1'b0) begin
         tests_failed++;
         $display("FAIL both_when_empty: rempty=%b rdata=%h wfull=%b, want 0 5a 0", rempty, rdata, wfull);
      end
      step(1'b0, 8'd0, 1'b1);
      tests_run++;
      if (rempty !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_drain: rempty=%b, want 1", rempty);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h30 + i), 1'b0);
      @(negedge wclk);
      wrst_n = 1'b0;
      model_q.delete();
      #1;
      tests_run++;
      if (rempty !== 1'b1 || rdata !== 8'h00 || wfull !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: rempty=%b rdata=%h wfull=%b, want 1 00 0", rempty, rdata, wfull);
      end
      @(negedge wclk);
      wrst_n = 1'b1;
      step(1'b1, 8'hA5, 1'b0);
      tests_run++;
      if (rdata !== 8'hA5 || rempty !== 1'b0) begin
         tests_failed++;
         $display("FAIL post_reset_write: rdata=%h rempty=%b, want a5 0", rdata, rempty);
      end
      step(1'b0, 8'd0, 1'b1);
      tests_run++;
      if (rempty !== 1'b1 || rdata !== 8'h00) begin
         tests_failed++;
         $display("FAIL post_reset_read: rempty=%b rdata=%h, want 1 00", rempty, rdata);
      end
   endtask

   task automatic test_random();
      logic [DW-1:0] exp_rdata;
      bit            bias_w;
      for (int i = 0; i < 600; i++) begin
         // Swing the write bias so the run visits both full and empty
         bias_w = ((i / 80) % 2) == 0;
         step(($urandom_range(0, 3) != 0) ? bias_w : ~bias_w,
              DW'($urandom), $urandom_range(0, 1) == 1);
         exp_rdata = (model_q.size() == 0) ? 8'h00 : model_q[0];
         tests_run++;
         if (rempty !== (model_q.size() == 0) || wfull !== (model_q.size() == DEPTH)
             || rdata !== exp_rdata) begin
            tests_failed++;
            $display("FAIL random[%0d]: rempty=%b wfull=%b rdata=%h, want %b %b %h",
                     i, rempty, wfull, rdata, (model_q.size() == 0),
                     (model_q.size() == DEPTH), exp_rdata);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_write();
      test_basic_read();
      test_full();
      test_simul();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
